// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared lane count, selector type and popcount helper for the round-robin dispatcher
package dispatch_pkg;
    localparam int LANES = 4;
    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] lane_sel_t;
    function automatic logic [2:0] popcount4(input logic [LANES-1:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction
endpackage

// File: rtl/demux_1x4.sv
// demux_1x4: routes y to the selected output, all other outputs read zero
module demux_1x4
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]      y,
    input  lane_sel_t             sel,
    output logic [3:0][WIDTH-1:0] d
);
    always_comb begin
        d = '0;
        d[sel] = y;
    end
endmodule

// File: rtl/lane_slot.sv
// lane_slot: one-entry holding register; a load wins over a same-cycle drain so the lane stays full
module lane_slot #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= din;
        end else if (full && ready) begin
            full <= 1'b0;
            data <= '0;
        end
    end
endmodule

// File: rtl/demux_1x4_dispatch.sv
// demux_1x4_dispatch: strict round-robin dispatch of one valid/ready stream onto four registered lanes
module demux_1x4_dispatch
    import dispatch_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [3:0][WIDTH-1:0] out_data,
    output lane_sel_t             sel,
    output logic [2:0]            occupancy
);
    lane_sel_t        ptr;
    logic [2:0]       occ;
    logic [3:0]       full;
    logic [3:0]       drain;
    logic [3:0][0:0]  ld;
    logic             acc;

    // the pointer never skips a busy lane, so readiness looks only at lane ptr
    assign in_ready  = ~full[ptr] | out_ready[ptr];
    assign acc       = in_valid & in_ready;
    assign drain     = full & out_ready;
    assign out_valid = full;
    assign sel       = ptr;
    assign occupancy = occ;

    demux_1x4 #(.WIDTH(1)) u_dec (.y(acc), .sel(ptr), .d(ld));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_slot #(.WIDTH(WIDTH)) u_slot (
            .clk(clk), .rst_n(rst_n), .load(ld[i]), .ready(out_ready[i]),
            .din(in_data), .full(full[i]), .data(out_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            occ <= '0;
        end else begin
            if (acc) ptr <= ptr + 1'b1;
            occ <= occ + {2'b0, acc} - popcount4(drain);
        end
    end
endmodule

// File: tb/tb_demux_1x4_dispatch.sv
// tb_demux_1x4_dispatch: directed and randomized checks against a queue-per-lane reference model
module tb_demux_1x4_dispatch;
    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_data = '0;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready = '0;
    logic [3:0][1:0] out_data;
    logic [1:0]      sel;
    logic [2:0]      occupancy;

    int checks = 0;
    int errors = 0;

    logic [1:0] mq[4][$];
    int         mptr = 0;
    logic [1:0] in_log[$];
    logic [1:0] dut_log[4][$];

    demux_1x4_dispatch #(.WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sel(sel), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            dut_log[i].delete();
        end
        in_log.delete();
        mptr = 0;
    endtask

    // each lane is a queue of at most one word; drains happen before the new load
    task automatic model_step(input logic v, input logic [1:0] d, input logic [3:0] r);
        bit rdy;
        rdy = (mq[mptr].size() == 0) || r[mptr];
        for (int i = 0; i < 4; i++)
            if (r[i] && mq[i].size() != 0) void'(mq[i].pop_front());
        if (v && rdy) begin
            mq[mptr].push_back(d);
            mptr = (mptr + 1) % 4;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [3:0] r);
        in_valid = v;
        in_data = d;
        out_ready = r;
        #1;
        for (int i = 0; i < 4; i++)
            if (out_valid[i] && r[i]) dut_log[i].push_back(out_data[i]);
        if (v && in_ready) in_log.push_back(d);
        model_step(v, d, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 2'd0, 4'h0);
        checks++; if (out_valid !== 4'b0000 || sel !== 2'd0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL idle_after_reset: got valid=%b sel=%0d occ=%0d expected 0000/0/0", out_valid, sel, occupancy);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data = 2'(k);
            out_ready = 4'hf;
            #1;
            checks++; if (sel !== 2'(k) || in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_sel_ready: got sel=%0d ready=%b expected sel=%0d ready=1", sel, in_ready, k);
            end
            drive(1'b1, 2'(k), 4'hf);
            checks++; if (out_valid !== 4'(1 << k)) begin errors++; $display("FAIL stream_valid: got %b expected %b", out_valid, 4'(1 << k)); end
            checks++; if (out_data !== 8'(k << (2 * k))) begin errors++; $display("FAIL stream_data: got %h expected %h", out_data, 8'(k << (2 * k))); end
        end
        drive(1'b0, 2'd0, 4'hf);
        checks++; if (out_valid !== 4'b0000 || out_data !== 8'h00 || sel !== 2'd0) begin
            errors++; $display("FAIL stream_clear: got valid=%b data=%h sel=%0d expected 0000/00/0", out_valid, out_data, sel);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 6; k++) drive(1'b1, 2'((in_log.size() + 1) % 4), 4'h0);
        checks++; if (in_log.size() != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", in_log.size()); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy); end
        checks++; if (in_ready !== 1'b0 || sel !== 2'd0) begin errors++; $display("FAIL bp_stall: got ready=%b sel=%0d expected 0/0", in_ready, sel); end
        checks++; if (out_data !== 8'h39) begin errors++; $display("FAIL bp_hold_data: got %h expected 39", out_data); end
        in_valid = 1'b1;
        in_data = 2'd2;
        out_ready = 4'b0001;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_lane0_ready: got %b expected 1", in_ready); end
        drive(1'b1, 2'd2, 4'b0001);
        checks++; if (out_valid !== 4'hf || out_data !== 8'h3a) begin
            errors++; $display("FAIL bp_reload: got valid=%b data=%h expected 1111/3a", out_valid, out_data);
        end
        checks++; if (occupancy !== 3'd4 || sel !== 2'd1) begin errors++; $display("FAIL bp_after_reload: got occ=%0d sel=%0d expected 4/1", occupancy, sel); end
        drive(1'b0, 2'd0, 4'hf);
        checks++; if (occupancy !== 3'd0 || out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain: got occ=%0d valid=%b expected 0/0000", occupancy, out_valid); end
    endtask

    task automatic test_lane_block();
        int total;
        do_reset();
        for (int k = 0; k < 8; k++) drive(1'b1, 2'((in_log.size() + 1) % 4), 4'b1101);
        checks++; if (in_log.size() != 5) begin errors++; $display("FAIL block_accepted: got %0d expected 5", in_log.size()); end
        checks++; if (in_ready !== 1'b0 || sel !== 2'd1) begin errors++; $display("FAIL block_stall: got ready=%b sel=%0d expected 0/1", in_ready, sel); end
        checks++; if (out_valid !== 4'b0010 || out_data !== 8'h08 || occupancy !== 3'd1) begin
            errors++; $display("FAIL block_state: got valid=%b data=%h occ=%0d expected 0010/08/1", out_valid, out_data, occupancy);
        end
        for (int k = 0; k < 4; k++) drive(1'b1, 2'((in_log.size() + 1) % 4), 4'hf);
        drive(1'b0, 2'd0, 4'hf);
        drive(1'b0, 2'd0, 4'hf);
        total = 0;
        for (int i = 0; i < 4; i++) total += dut_log[i].size();
        checks++; if (total != in_log.size()) begin errors++; $display("FAIL block_count: got %0d expected %0d", total, in_log.size()); end
        for (int n = 0; n < in_log.size(); n++) begin
            checks++;
            if (n / 4 >= dut_log[n % 4].size()) begin errors++; $display("FAIL block_order: word %0d missing", n); end
            else if (dut_log[n % 4][n / 4] !== in_log[n]) begin
                errors++; $display("FAIL block_order: word %0d got %0d expected %0d", n, dut_log[n % 4][n / 4], in_log[n]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 2'd1, 4'h0);
        drive(1'b1, 2'd2, 4'h0);
        drive(1'b1, 2'd3, 4'h0);
        checks++; if (occupancy !== 3'd3 || sel !== 2'd3) begin errors++; $display("FAIL areset_setup: got occ=%0d sel=%0d expected 3/3", occupancy, sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000 || out_data !== 8'h00) begin errors++; $display("FAIL areset_outputs: got valid=%b data=%h expected 0000/00", out_valid, out_data); end
        checks++; if (occupancy !== 3'd0 || sel !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_state: got occ=%0d sel=%0d ready=%b expected 0/0/1", occupancy, sel, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 4'h0);
        checks++; if (out_valid !== 4'b0001 || out_data !== 8'h02 || sel !== 2'd1) begin
            errors++; $display("FAIL areset_first_word: got valid=%b data=%h sel=%0d expected 0001/02/1", out_valid, out_data, sel);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [1:0] d;
        logic [3:0] r, ev;
        logic [7:0] ed;
        int         n, total;
        bit         er;
        do_reset();
        for (int c = 0; c < 10000 && errors < 20; c++) begin
            v = ($urandom % 4) != 0;
            d = 2'($urandom);
            r = (c % 2000 < 1000) ? 4'($urandom) : 4'($urandom | $urandom);
            in_valid = v;
            in_data = d;
            out_ready = r;
            #1;
            ev = '0;
            ed = '0;
            n = 0;
            for (int i = 0; i < 4; i++)
                if (mq[i].size() != 0) begin
                    ev[i] = 1'b1;
                    ed[2*i +: 2] = mq[i][0];
                    n++;
                end
            er = (mq[mptr].size() == 0) || r[mptr];
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, in_ready, er); end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL rand_valid c%0d: got %b expected %b", c, out_valid, ev); end
            checks++; if (out_data !== ed) begin errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, out_data, ed); end
            checks++; if (sel !== 2'(mptr)) begin errors++; $display("FAIL rand_sel c%0d: got %0d expected %0d", c, sel, mptr); end
            checks++; if (occupancy !== 3'($countones(out_valid)) || occupancy !== 3'(n) || occupancy > 3'd4) begin
                errors++; $display("FAIL rand_occupancy c%0d: got %0d expected %0d", c, occupancy, n);
            end
            drive(v, d, r);
        end
        drive(1'b0, 2'd0, 4'hf);
        drive(1'b0, 2'd0, 4'hf);
        total = 0;
        for (int i = 0; i < 4; i++) total += dut_log[i].size();
        checks++; if (total != in_log.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", total, in_log.size()); end
        for (int k = 0; k < in_log.size(); k++) begin
            checks++;
            if (k / 4 >= dut_log[k % 4].size()) begin errors++; $display("FAIL rand_order: word %0d missing", k); end
            else if (dut_log[k % 4][k / 4] !== in_log[k]) begin
                errors++; $display("FAIL rand_order: word %0d got %0d expected %0d", k, dut_log[k % 4][k / 4], in_log[k]);
            end
            if (errors >= 20) break;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_lane_block();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
